// File: rtl/axi4_lite_master.sv
// axi4_lite_master: turns single core requests into AXI4-Lite read or write
// transactions, with at most one transaction in flight at a time.
// Optional feature: define AXI_MASTER_TIMEOUT_EN to abort any transaction
// that stays outside IDLE for TIMEOUT_CYCLES cycles.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A valid, once raised, stays high with its payload held
// stable until that edge. The only exception is a timeout abort. Every AXI
// valid and ready is driven straight from a flop.
module axi4_lite_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        m_axi_aclk_i,
  input  logic        m_axi_aresetn_i,
  // core request
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  // core response
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  // AR / R
  output logic [31:0] m_axi_araddr_o,
  output logic        m_axi_arvalid_o,
  input  logic        m_axi_arready_i,
  input  logic [31:0] m_axi_rdata_i,
  input  logic [1:0]  m_axi_rresp_i,
  input  logic        m_axi_rvalid_i,
  output logic        m_axi_rready_o,
  // AW / W / B
  output logic [31:0] m_axi_awaddr_o,
  output logic        m_axi_awvalid_o,
  input  logic        m_axi_awready_i,
  output logic [31:0] m_axi_wdata_o,
  output logic [3:0]  m_axi_wstrb_o,
  output logic        m_axi_wvalid_o,
  input  logic        m_axi_wready_i,
  input  logic [1:0]  m_axi_bresp_i,
  input  logic        m_axi_bvalid_i,
  output logic        m_axi_bready_o,
  // debug: current FSM state
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        accept;
  logic        aw_pending, w_pending;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] timer_q, timer_d;
  logic          unused_resp_lsb;
  assign unused_resp_lsb = ^{m_axi_bresp_i[0], m_axi_rresp_i[0]};
`else
  logic unused_resp_lsb;
  assign unused_resp_lsb = ^{m_axi_bresp_i[0], m_axi_rresp_i[0], (TIMEOUT_CYCLES == 0)};
`endif

  // The request port is open only in IDLE, and never while reset is asserted.
  assign req_ready_o = (state_q == IDLE) && m_axi_aresetn_i;
  assign accept      = req_valid_i && req_ready_o;

  assign aw_pending  = awvalid_q && !m_axi_awready_i;
  assign w_pending   = wvalid_q && !m_axi_wready_i;

  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_rready_o  = rready_q;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = wstrb_q;
  assign m_axi_wvalid_o  = wvalid_q;
  assign m_axi_bready_o  = bready_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_rdata_o    = resp_rdata_q;
  assign resp_err_o      = resp_err_q;
  assign dbg_state_o     = state_q;

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef AXI_MASTER_TIMEOUT_EN
    timer_d      = timer_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          wstrb_d = req_wstrb_i;
          if (req_write_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR: begin
        // AW and W complete independently; B is only opened once both have.
        awvalid_d = aw_pending;
        wvalid_d  = w_pending;
        if (!aw_pending && !w_pending) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid_i) begin
          bready_d     = 1'b0;
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'h0;
          resp_err_d   = m_axi_bresp_i[1];
        end
      end
      RD_ADDR: begin
        if (m_axi_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid_i) begin
          rready_d     = 1'b0;
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = m_axi_rdata_i;
          resp_err_d   = m_axi_rresp_i[1];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    // Abort overrides whatever the FSM decided this cycle.
    if (accept) begin
      timer_d = '0;
    end else if (state_q != IDLE) begin
      if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        awvalid_d    = 1'b0;
        wvalid_d     = 1'b0;
        bready_d     = 1'b0;
        arvalid_d    = 1'b0;
        rready_d     = 1'b0;
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b1;
        timer_d      = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
`endif
  end

  // State and output registers; reset abandons any transaction silently.
  always_ff @(posedge m_axi_aclk_i or negedge m_axi_aresetn_i) begin
    if (!m_axi_aresetn_i) begin
      state_q      <= IDLE;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
`ifdef AXI_MASTER_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

endmodule
